// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall scheduler.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MEM_WAIT = 3'd1,
        DRAIN    = 3'd2,
        HALTED   = 3'd3,
        ERROR    = 3'd4
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bits needed to hold every value from 0 to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a
// load in EX is about to write. Register 0 never creates a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rt,
    input  logic       ex_memread,
    output logic       lu
);

    // Dependency on rs always counts; rt only when the instruction sources it.
    always_comb begin
        lu = ex_memread && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; load-use, branch flush, mem stall, halt checks
// MEM_WAIT | data memory busy; pipe frozen, timeout counter running
// DRAIN    | injecting bubbles before acknowledging halt
// HALTED   | pipe drained and frozen, halt_ack high
// ERROR    | memory timeout; frozen until reset
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_memread,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_hold,
    output logic        halt_ack,
    output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int WAIT_W  = cnt_width(MEM_TIMEOUT);
    localparam int DRAIN_W = cnt_width(DRAIN_CYCLES);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);

    hz_state_t          state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;
    logic               mem_err_q;
    logic               lu;
    logic               mem_stall;
    logic               br_flush;

    load_use_detect u_lu (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_rt      (ex_rt),
        .ex_memread (ex_memread),
        .lu         (lu)
    );

    assign mem_stall = mem_req && !mem_ready;
    assign mem_err   = mem_err_q;

    // State, counters and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            mem_err_q <= (state_nxt == ERROR);
        end
    end

    // Next-state and pipeline control; reset overrides outputs without a clock.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        drain_cnt_nxt = drain_cnt;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        pipe_hold     = 1'b0;
        halt_ack      = 1'b0;
        br_flush      = 1'b0;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    pipe_hold    = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else if (branch_taken) begin
                    // Wrong-path instruction in ID is killed, so a load-use on it is moot.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    br_flush   = 1'b1;
                end else if (lu) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (halt_req) begin
                    pc_write      = 1'b0;
                    ifid_flush    = 1'b1;
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DRAIN_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ERROR;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            DRAIN: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (mem_stall) begin
                    pipe_hold = 1'b1;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt     = HALTED;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
                end
            end
            HALTED: begin
                halt_ack   = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
                if (!halt_req) begin
                    state_nxt = RUN;
                end
            end
            ERROR: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pipe_hold  = 1'b0;
            halt_ack   = 1'b0;
            br_flush   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating stall and branch-flush event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (state != HALTED) && (state != ERROR) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (br_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// every output compared each cycle against a behavioural model of the scheduler.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 8;
    localparam int DC = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_memread, branch_taken, mem_req, mem_ready, halt_req;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, halt_ack, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .DRAIN_CYCLES(DC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_rt        (ex_rt),
        .ex_memread   (ex_memread),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .halt_req     (halt_req),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .pipe_hold    (pipe_hold),
        .halt_ack     (halt_ack),
        .mem_err      (mem_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: consecutive memory hold cycles so far (0 = not waiting),
    // bubbles still owed before halt (0 = not draining), halted, errored.
    int m_holds;
    int m_left;
    bit m_halted;
    bit m_err;
    int m_stall;
    int m_flush;
    logic e_pw, e_iw, e_ifl, e_idf, e_ph, e_ha, e_br;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_holds = 0; m_left = 0; m_halted = 0; m_err = 0;
        m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit dep, mstall;
        dep = ex_memread && ex_rt != 5'd0 &&
              (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        mstall = mem_req && !mem_ready;
        e_pw = 1; e_iw = 1; e_ifl = 0; e_idf = 0; e_ph = 0; e_ha = 0; e_br = 0;
        if (!rst_n) begin
            e_pw = 0; e_iw = 0; e_ifl = 1; e_idf = 1;
        end else if (m_err) begin
            e_pw = 0; e_iw = 0; e_ph = 1;
        end else if (m_halted) begin
            e_ha = 1; e_pw = 0; e_iw = 0; e_ph = 1;
        end else if (m_left > 0) begin
            e_pw = 0; e_ifl = 1; e_idf = 1; e_ph = mstall;
        end else if (m_holds > 0) begin
            if (!mem_ready) begin e_pw = 0; e_iw = 0; e_ph = 1; end
        end else if (mstall) begin
            e_pw = 0; e_iw = 0; e_ph = 1;
        end else if (branch_taken) begin
            e_ifl = 1; e_idf = 1; e_br = 1;
        end else if (dep) begin
            e_pw = 0; e_iw = 0; e_idf = 1;
        end else if (halt_req) begin
            e_pw = 0; e_ifl = 1;
        end
    endtask

    task automatic model_step();
        bit mstall;
        mstall = mem_req && !mem_ready;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!e_pw && !m_halted && !m_err) m_stall++;
        if (e_br) m_flush++;
        if (m_err) begin
        end else if (m_halted) begin
            if (!halt_req) m_halted = 0;
        end else if (m_left > 0) begin
            if (!mstall) begin
                m_left--;
                if (m_left == 0) m_halted = 1;
            end
        end else if (m_holds > 0) begin
            if (mem_ready) m_holds = 0;
            else begin
                m_holds++;
                if (m_holds == TO) begin m_holds = 0; m_err = 1; end
            end
        end else if (mstall) begin
            m_holds = 1;
        end else if (!branch_taken && !e_idf && halt_req) begin
            m_left = DC;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_write"},   pc_write,   e_pw);
        chk({tag, ".ifid_write"}, ifid_write, e_iw);
        chk({tag, ".ifid_flush"}, ifid_flush, e_ifl);
        chk({tag, ".idex_flush"}, idex_flush, e_idf);
        chk({tag, ".pipe_hold"},  pipe_hold,  e_ph);
        chk({tag, ".halt_ack"},   halt_ack,   e_ha);
        chk({tag, ".mem_err"},    mem_err,    m_err);
`ifdef HAZARD_PERF_CNT_EN
        n_assert++;
        assert (stall_cnt === 32'(m_stall)) else begin
            n_fail++;
            $error("FAIL %s.stall_cnt: observed %0d expected %0d", tag, stall_cnt, m_stall);
        end
        n_assert++;
        assert (flush_cnt === 32'(m_flush)) else begin
            n_fail++;
            $error("FAIL %s.flush_cnt: observed %0d expected %0d", tag, flush_cnt, m_flush);
        end
`endif
    endtask

    // One clock: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic cyc(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] ert, input logic emr,
                       input logic br, input logic mreq, input logic mrdy, input logic hreq);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rt = ert; ex_memread = emr;
        branch_taken = br; mem_req = mreq; mem_ready = mrdy; halt_req = hreq;
        #1;
        model_eval();
        check_all(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle; outputs must respond before any clock edge.
    task automatic apply_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        model_eval();
        check_all(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic hreq_lvl;

    initial begin
        rst_n = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_rt = '0; ex_memread = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0; halt_req = 0;
        model_reset();
        @(negedge clk);
        apply_reset("reset");

        cyc("idle", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);

        // Load-use on rs: one bubble, then normal flow.
        cyc("lu_rs", 5'd8, 5'd2, 0, 5'd8, 1, 0, 0, 0, 0);
        cyc("lu_after", 5'd8, 5'd2, 0, 5'd8, 0, 0, 0, 0, 0);
        cyc("lu_rt", 5'd1, 5'd9, 1, 5'd9, 1, 0, 0, 0, 0);
        cyc("lu_rt_unused", 5'd1, 5'd9, 0, 5'd9, 1, 0, 0, 0, 0);
        cyc("lu_r0", 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0);

        // Branch wins over a coincident load-use.
        cyc("br_lu", 5'd8, 5'd2, 0, 5'd8, 1, 1, 0, 0, 0);
        cyc("br_after", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);

        // Five-cycle memory wait, released in the ready cycle.
        for (int i = 0; i < 5; i++) cyc("memwait", 5'd1, 5'd2, 0, 5'd8, 1, 1, 1, 0, 0);
        cyc("mem_release", 5'd8, 5'd2, 0, 5'd8, 1, 1, 1, 1, 0);
        cyc("mem_run", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);
        cyc("mem_ready_same", 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 1, 0);

        // Halt with one memory stall inside the drain, then release.
        cyc("halt_enter", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
        cyc("drain", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
        cyc("drain_stall", 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 1);
        for (int i = 0; i < DC + 1; i++) cyc("drain_to_halt", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
        chk("halt_ack_reached", halt_ack, 1'b1);
        cyc("halted_hold", 5'd1, 5'd2, 0, 5'd3, 0, 1, 1, 0, 1);
        cyc("halt_drop", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);
        cyc("halt_run", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);

        // Halt request dropped mid-drain: drain completes, HALTED bounces to RUN.
        cyc("halt2_enter", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
        for (int i = 0; i < DC + 2; i++) cyc("halt2_drop", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);

        // Reset while waiting on memory, then a long wait must not inherit the count.
        for (int i = 0; i < 4; i++) cyc("pre_rst_wait", 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0);
        apply_reset("rst_in_wait");
        for (int i = 0; i < TO - 1; i++) cyc("post_rst_wait", 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0);
        cyc("post_rst_rel", 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 1, 0);
        chk("no_err_after_rst", mem_err, 1'b0);

        // Timeout: error after TO hold cycles, sticky until reset.
        for (int i = 0; i < TO + 4; i++) cyc("timeout", 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0);
        chk("mem_err_sticky", mem_err, 1'b1);
        cyc("err_ready", 5'd8, 5'd2, 0, 5'd8, 1, 1, 1, 1, 1);
        apply_reset("rst_from_err");
        cyc("err_cleared", 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);

        // Random traffic over a small register range to provoke hazards.
        hreq_lvl = 0;
        for (int i = 0; i < 600; i++) begin
            logic [4:0] r_rs, r_rt, r_ert;
            if (m_err) apply_reset("rnd_rst");
            if ($urandom_range(9) == 0) hreq_lvl = ~hreq_lvl;
            r_rs  = 5'($urandom_range(3));
            r_rt  = 5'($urandom_range(3));
            r_ert = 5'($urandom_range(3));
            cyc("rnd", r_rs, r_rt, 1'($urandom_range(1)), r_ert, 1'($urandom_range(1)),
                ($urandom_range(5) == 0), ($urandom_range(2) == 0), ($urandom_range(3) != 0),
                hreq_lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
